// File: rtl/cmp_seq_arb.sv
// cmp_seq_arb: two-requester round-robin arbiter in front of a byte-serial
// a - b compare engine that produces x86 ZF/CF/SF/OF and signed ordering.
module cmp_seq_arb #(
    parameter int TAG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [31:0]      req0_a,
    input  logic [31:0]      req0_b,
    input  logic [1:0]       req0_size,
    input  logic [TAG_W-1:0] req0_tag,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [31:0]      req1_a,
    input  logic [31:0]      req1_b,
    input  logic [1:0]       req1_size,
    input  logic [TAG_W-1:0] req1_tag,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_src,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_zf,
    output logic             res_cf,
    output logic             res_sf,
    output logic             res_of,
    output logic             res_agb,
    output logic             res_bga
);

    typedef enum logic [1:0] {IDLE, BUSY, HOLD} state_t;

    state_t           state_q;
    logic             ptr_q;
    logic [31:0]      opA_q;
    logic [31:0]      opB_q;
    logic [1:0]       size_q;
    logic [TAG_W-1:0] tag_q;
    logic             src_q;
    logic [1:0]       slice_q;
    logic             carry_q;
    logic             zeroAcc_q;

    logic             resValid_q;
    logic             resSrc_q;
    logic [TAG_W-1:0] resTag_q;
    logic             resZf_q, resCf_q, resSf_q, resOf_q, resAgb_q, resBga_q;

    logic             grant0, grant1;
    logic [7:0]       aSlice, bSlice;
    logic [8:0]       sum_d;
    logic [1:0]       lastSlice;
    logic             zf_d, cf_d, sf_d, of_d;

    // Grant only in IDLE; pointer breaks ties so both requesters cannot be ready.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (state_q == IDLE) begin
            grant0 = req0_valid & (~req1_valid | ~ptr_q);
            grant1 = req1_valid & (~req0_valid |  ptr_q);
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;

    // Current byte slice and one 8-bit subtract step (a + ~b + carry).
    always_comb begin
        aSlice = opA_q[7:0];
        bSlice = opB_q[7:0];
        case (slice_q)
            2'd0: begin aSlice = opA_q[7:0];   bSlice = opB_q[7:0];   end
            2'd1: begin aSlice = opA_q[15:8];  bSlice = opB_q[15:8];  end
            2'd2: begin aSlice = opA_q[23:16]; bSlice = opB_q[23:16]; end
            default: begin aSlice = opA_q[31:24]; bSlice = opB_q[31:24]; end
        endcase
        sum_d = {1'b0, aSlice} + {1'b0, ~bSlice} + {8'd0, carry_q};
        case (size_q)
            2'b00:   lastSlice = 2'd0;
            2'b01:   lastSlice = 2'd1;
            default: lastSlice = 2'd3;
        endcase
        zf_d = zeroAcc_q & (sum_d[7:0] == 8'd0);
        cf_d = ~sum_d[8];
        sf_d = sum_d[7];
        of_d = (aSlice[7] ^ bSlice[7]) & (sum_d[7] ^ aSlice[7]);
    end

    // Control FSM with operand capture, slice iteration and registered results.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            ptr_q      <= 1'b0;
            slice_q    <= 2'd0;
            carry_q    <= 1'b1;
            zeroAcc_q  <= 1'b1;
            resValid_q <= 1'b0;
            resSrc_q   <= 1'b0;
            resTag_q   <= '0;
            resZf_q    <= 1'b0;
            resCf_q    <= 1'b0;
            resSf_q    <= 1'b0;
            resOf_q    <= 1'b0;
            resAgb_q   <= 1'b0;
            resBga_q   <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant0 | grant1) begin
                        opA_q     <= grant1 ? req1_a    : req0_a;
                        opB_q     <= grant1 ? req1_b    : req0_b;
                        size_q    <= grant1 ? req1_size : req0_size;
                        tag_q     <= grant1 ? req1_tag  : req0_tag;
                        src_q     <= grant1;
                        ptr_q     <= grant0;
                        slice_q   <= 2'd0;
                        carry_q   <= 1'b1;
                        zeroAcc_q <= 1'b1;
                        state_q   <= BUSY;
                    end
                end
                BUSY: begin
                    carry_q   <= sum_d[8];
                    zeroAcc_q <= zeroAcc_q & (sum_d[7:0] == 8'd0);
                    slice_q   <= slice_q + 2'd1;
                    if (slice_q == lastSlice) begin
                        resValid_q <= 1'b1;
                        resSrc_q   <= src_q;
                        resTag_q   <= tag_q;
                        resZf_q    <= zf_d;
                        resCf_q    <= cf_d;
                        resSf_q    <= sf_d;
                        resOf_q    <= of_d;
                        resAgb_q   <= ~zf_d & (sf_d == of_d);
                        resBga_q   <= ~zf_d & (sf_d != of_d);
                        state_q    <= HOLD;
                    end
                end
                HOLD: begin
                    if (res_ready) begin
                        resValid_q <= 1'b0;
                        state_q    <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign res_valid = resValid_q;
    assign res_src   = resSrc_q;
    assign res_tag   = resTag_q;
    assign res_zf    = resZf_q;
    assign res_cf    = resCf_q;
    assign res_sf    = resSf_q;
    assign res_of    = resOf_q;
    assign res_agb   = resAgb_q;
    assign res_bga   = resBga_q;

endmodule

// File: tb/tb_cmp_seq_arb.sv
// tb_cmp_seq_arb: directed and random operations against a reference model
// that derives flags from width-masked integer arithmetic and signed compares.
module tb_cmp_seq_arb;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_ready, req1_valid, req1_ready;
    logic [31:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]  req0_size, req1_size;
    logic [3:0]  req0_tag, req1_tag;
    logic        res_valid, res_ready, res_src;
    logic [3:0]  res_tag;
    logic        res_zf, res_cf, res_sf, res_of, res_agb, res_bga;

    int testsRun  = 0;
    int failCount = 0;
    logic refPtr;

    cmp_seq_arb #(.TAG_W(4)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a),
        .req0_b(req0_b), .req0_size(req0_size), .req0_tag(req0_tag),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a),
        .req1_b(req1_b), .req1_size(req1_size), .req1_tag(req1_tag),
        .res_valid(res_valid), .res_ready(res_ready), .res_src(res_src),
        .res_tag(res_tag), .res_zf(res_zf), .res_cf(res_cf), .res_sf(res_sf),
        .res_of(res_of), .res_agb(res_agb), .res_bga(res_bga)
    );

    // 10 ns clock.
    always #5 clk = ~clk;

    // Watchdog so a wedged design still ends the run.
    initial begin
        #2ms;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        testsRun++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Flags as {zf, cf, sf, of, agb, bga} from the operands viewed as w-bit integers.
    function automatic logic [5:0] refFlags(input logic [31:0] a, input logic [31:0] b,
                                            input logic [1:0] size);
        int          w;
        longint      mask, am, bm, diff, sa, sb;
        logic        zf, cf, sf, ofl, agb, bga;
        w    = (size == 2'b00) ? 8 : (size == 2'b01) ? 16 : 32;
        mask = (longint'(1) << w) - 1;
        am   = longint'(a) & mask;
        bm   = longint'(b) & mask;
        diff = (am - bm) & mask;
        sa   = (am >= (longint'(1) << (w - 1))) ? am - (longint'(1) << w) : am;
        sb   = (bm >= (longint'(1) << (w - 1))) ? bm - (longint'(1) << w) : bm;
        zf   = (diff == 0);
        cf   = (am < bm);
        sf   = diff[w-1];
        ofl  = sf != (sa < sb);
        agb  = sa > sb;
        bga  = sb > sa;
        return {zf, cf, sf, ofl, agb, bga};
    endfunction

    function automatic logic [5:0] dutFlags();
        return {res_zf, res_cf, res_sf, res_of, res_agb, res_bga};
    endfunction

    // One full operation: present requests, check grant, latency, result, hold and release.
    task automatic applyStimulus(input bit v0, input logic [31:0] a0, input logic [31:0] b0,
                                 input logic [1:0] s0, input bit v1, input logic [31:0] a1,
                                 input logic [31:0] b1, input logic [1:0] s1,
                                 input int holdCycles);
        int          g, n, cyc;
        logic [3:0]  t0, t1, expTag;
        logic [5:0]  expFlags;
        logic [14:0] snap;
        t0 = 4'($urandom);
        t1 = ~t0;
        @(posedge clk); #1;
        req0_valid = v0; req0_a = a0; req0_b = b0; req0_size = s0; req0_tag = t0;
        req1_valid = v1; req1_a = a1; req1_b = b1; req1_size = s1; req1_tag = t1;
        res_ready  = 1'b0;
        g = (v0 && v1) ? int'(refPtr) : (v1 ? 1 : 0);
        @(negedge clk);
        checkOutput("grant0", {31'd0, req0_ready}, {31'd0, g == 0});
        checkOutput("grant1", {31'd0, req1_ready}, {31'd0, g == 1});
        @(posedge clk); #1;
        if (g == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        refPtr   = (g == 0);
        expFlags = (g == 0) ? refFlags(a0, b0, s0) : refFlags(a1, b1, s1);
        expTag   = (g == 0) ? t0 : t1;
        n        = ((g == 0 ? s0 : s1) == 2'b00) ? 1 : ((g == 0 ? s0 : s1) == 2'b01) ? 2 : 4;
        cyc = 0;
        while (1) begin
            @(negedge clk);
            cyc++;
            if (res_valid) break;
            if (cyc > 20) break;
        end
        checkOutput("latency", cyc, n + 1);
        checkOutput("flags", {26'd0, dutFlags()}, {26'd0, expFlags});
        checkOutput("src", {31'd0, res_src}, g);
        checkOutput("tag", {28'd0, res_tag}, {28'd0, expTag});
        snap = {res_valid, res_src, res_tag, res_zf, res_cf, res_sf, res_of, res_agb, res_bga, 3'b000};
        for (int i = 0; i < holdCycles; i++) begin
            @(negedge clk);
            checkOutput("holdStable",
                        {17'd0, res_valid, res_src, res_tag, res_zf, res_cf, res_sf, res_of,
                         res_agb, res_bga, 3'b000}, {17'd0, snap});
            checkOutput("holdReady", {30'd0, req1_ready, req0_ready}, 32'd0);
        end
        @(posedge clk); #1;
        res_ready = 1'b1;
        @(posedge clk); #1;
        res_ready  = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(negedge clk);
        checkOutput("released", {31'd0, res_valid}, 32'd0);
    endtask

    // Directed scenarios, mid-operation reset, then a randomized sweep.
    initial begin
        rst = 1'b1; res_ready = 1'b0; refPtr = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_size = '0; req0_tag = '0;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_size = '0; req1_tag = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        checkOutput("rstValid", {31'd0, res_valid}, 32'd0);
        checkOutput("rstFlags", {26'd0, dutFlags()}, 32'd0);
        checkOutput("rstReady", {30'd0, req1_ready, req0_ready}, 32'd0);

        // Simultaneous requests alternate starting with requester 0.
        applyStimulus(1, 32'h10, 32'h20, 2'b00, 1, 32'h1234, 32'h1234, 2'b01, 0);
        applyStimulus(1, 32'h10, 32'h20, 2'b00, 1, 32'h1234, 32'h1234, 2'b01, 0);
        applyStimulus(1, 32'h80, 32'h01, 2'b00, 1, 32'h0, 32'h1, 2'b10, 0);

        applyStimulus(1, 32'h05, 32'h07, 2'b00, 0, 32'h0, 32'h0, 2'b00, 1);
        applyStimulus(0, 32'h0, 32'h0, 2'b00, 1, 32'h7FFFFFFF, 32'hFFFFFFFF, 2'b10, 1);
        applyStimulus(1, 32'hAB121234, 32'h00001234, 2'b01, 0, 32'h0, 32'h0, 2'b00, 10);
        applyStimulus(1, 32'h00000001, 32'h00000002, 2'b11, 0, 32'h0, 32'h0, 2'b00, 0);

        // Reset during BUSY of a 32-bit op drops it and restores pointer to 0.
        @(posedge clk); #1;
        req0_valid = 1'b1; req0_a = 32'h1; req0_b = 32'h2; req0_size = 2'b10;
        @(posedge clk); #1;
        req0_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        refPtr = 1'b0;
        @(negedge clk);
        checkOutput("midRstValid", {31'd0, res_valid}, 32'd0);
        checkOutput("midRstFlags", {26'd0, dutFlags()}, 32'd0);
        applyStimulus(1, 32'hDEADBEEF, 32'hDEADBEEF, 2'b10, 1, 32'h5, 32'h3, 2'b00, 0);

        for (int i = 0; i < 60; i++) begin
            bit          v0, v1;
            logic [31:0] a0, b0, a1, b1;
            v0 = 1'($urandom_range(0, 1));
            v1 = v0 ? 1'($urandom_range(0, 1)) : 1'b1;
            a0 = $urandom; a1 = $urandom;
            b0 = ($urandom_range(0, 3) == 0) ? (a0 ^ ($urandom << 16)) : $urandom;
            b1 = ($urandom_range(0, 3) == 0) ? a1 : $urandom;
            applyStimulus(v0, a0, b0, 2'($urandom_range(0, 3)),
                          v1, a1, b1, 2'($urandom_range(0, 3)),
                          $urandom_range(0, 3));
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule
